// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core with on-the-fly key expansion.
// SBOX_LANES state bytes are substituted per cycle; a round completes every 16/SBOX_LANES cycles.
module aes128_encrypt_iter #(
  parameter int SBOX_LANES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] Block,
  input  logic [127:0] Key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] Result
);

  localparam int RCYC = 16 / SBOX_LANES;
  localparam int SW   = (RCYC > 1) ? $clog2(RCYC) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(RCYC - 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  fsm_e             fsm_q;
  logic [3:0]       round_q;
  logic [SW-1:0]    sub_q;
  logic [15:0][7:0] state_q;
  logic [15:0][7:0] temp_q;
  logic [127:0]     rkey_q;
  logic [127:0]     result_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [15:0][7:0] temp_d;
  logic [127:0]     nextkey_d;
  logic [127:0]     state_d;

  // Table entry x sits at bits [8*(255-x)+7 -: 8]
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte (r,c) lives at index r+4c; ShiftRows rotates row r left by r columns.
  function automatic logic [127:0] round_fn(input logic [15:0][7:0] t, input logic [127:0] k,
                                            input logic last);
    logic [15:0][7:0] sr;
    logic [3:0][31:0] mc;
    logic [31:0]      col;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4'(15 - (r + 4*c))] = t[4'(15 - (r + 4*((c + r) % 4)))];
      end
    end
    for (int c = 0; c < 4; c++) begin
      col = sr[4'(15 - 4*c) -: 4];
      mc[2'(3 - c)] = last ? col : mixcol(col);
    end
    return mc ^ k;
  endfunction

  // Current slice substituted on top of the slices already collected this round
  always_comb begin
    temp_d = temp_q;
    for (int l = 0; l < SBOX_LANES; l++) begin
      temp_d[4'(15 - (int'(sub_q) * SBOX_LANES + l))] =
        sbox(state_q[4'(15 - (int'(sub_q) * SBOX_LANES + l))]);
    end
  end

  assign nextkey_d = key_next(rkey_q, rcon(round_q));
  assign state_d   = round_fn(temp_d, nextkey_d, round_q == 4'd10);

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      sub_q       <= '0;
      state_q     <= '0;
      temp_q      <= '0;
      rkey_q      <= 128'd0;
      result_q    <= 128'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= Block ^ Key;
            rkey_q     <= Key;
            round_q    <= 4'd1;
            sub_q      <= '0;
            in_ready_q <= 1'b0;
            fsm_q      <= ROUND;
          end
        end
        ROUND: begin
          temp_q <= temp_d;
          if (sub_q == SUB_LAST) begin
            state_q <= state_d;
            rkey_q  <= nextkey_d;
            sub_q   <= '0;
            if (round_q == 4'd10) begin
              result_q    <= state_d;
              out_valid_q <= 1'b1;
              fsm_q       <= DONE;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end else begin
            sub_q <= sub_q + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench: three cores (16, 8 and 4 lanes) fed the same blocks in lockstep,
// expected ciphertexts queued on accept and compared when each core presents its result.
module tb_aes128_encrypt_iter;

  localparam int LANES [3] = '{16, 8, 4};

  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] blk, key;
  logic [2:0]   in_valid, out_ready, in_ready, out_valid;
  logic [127:0] res [3];

  logic [127:0] sb0[$], sb1[$], sb2[$];
  vec_t         vecs [3];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes128_encrypt_iter #(.SBOX_LANES(LANES[g])) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .Block    (blk),
      .Key      (key),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .Result   (res[g])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] sb_pop(input int i);
    logic [127:0] v;
    v = 'x;
    case (i)
      0: if (sb0.size() > 0) v = sb0.pop_front();
      1: if (sb1.size() > 0) v = sb1.pop_front();
      default: if (sb2.size() > 0) v = sb2.pop_front();
    endcase
    return v;
  endfunction

  // One block through all three cores; hold = cycles out_ready stays low after out_valid.
  task automatic run_vec(input vec_t v, input int hold, input bit toggle, input bit pulse);
    int           ph [3];
    int           hc [3];
    bit           hs [3];
    logic [127:0] cur [3];
    int           cyc;
    chk("in_ready_before_accept", {125'd0, in_ready}, {125'd0, 3'b111});
    blk       = v.blk;
    key       = v.key;
    in_valid  = 3'b111;
    out_ready = 3'b000;
    sb0.push_back(v.exp);
    sb1.push_back(v.exp);
    sb2.push_back(v.exp);
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0;
      hc[i] = 0;
      hs[i] = 1'b0;
    end
    cyc = 0;
    while ((ph[0] != 2 || ph[1] != 2 || ph[2] != 2) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      in_valid = 3'b000;
      if (toggle) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < 3; i++) begin
        case (ph[i])
          0: begin
            if (out_valid[i]) begin
              chk($sformatf("latency_l%0d", LANES[i]), 128'(cyc), 128'(1 + 10 * (16 / LANES[i])));
              cur[i] = sb_pop(i);
              chk($sformatf("result_l%0d", LANES[i]), res[i], cur[i]);
              ph[i]        = 1;
              hs[i]        = (hold == 0);
              out_ready[i] = (hold == 0);
            end else begin
              chk1($sformatf("busy_in_ready_l%0d", LANES[i]), in_ready[i], 1'b0);
            end
          end
          1: begin
            if (hs[i]) begin
              chk1($sformatf("post_hs_out_valid_l%0d", LANES[i]), out_valid[i], 1'b0);
              chk1($sformatf("post_hs_in_ready_l%0d", LANES[i]), in_ready[i], 1'b1);
              out_ready[i] = 1'b0;
              ph[i]        = 2;
            end else begin
              chk($sformatf("held_result_l%0d", LANES[i]), res[i], cur[i]);
              chk1($sformatf("held_out_valid_l%0d", LANES[i]), out_valid[i], 1'b1);
              chk1($sformatf("held_in_ready_l%0d", LANES[i]), in_ready[i], 1'b0);
              hc[i]++;
              if (hc[i] >= hold) begin
                out_ready[i] = 1'b1;
                hs[i]        = 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (pulse && ph[i] != 2) in_valid[i] = 1'($urandom_range(0, 1));
      end
    end
    chk1("completed_in_budget", (ph[0] == 2 && ph[1] == 2 && ph[2] == 2), 1'b1);
    in_valid  = 3'b000;
    out_ready = 3'b000;
  endtask

  initial begin
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                blk: 128'h3243f6a8885a308d313198a2e0370734,
                exp: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                blk: 128'h00112233445566778899aabbccddeeff,
                exp: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'd0, blk: 128'd0,
                exp: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    reset     = 1'b1;
    in_valid  = 3'b000;
    out_ready = 3'b000;
    blk       = 128'd0;
    key       = 128'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {125'd0, out_valid}, 128'd0);
    chk("reset_in_ready", {125'd0, in_ready}, {125'd0, 3'b111});
    for (int i = 0; i < 3; i++) chk($sformatf("reset_result_l%0d", LANES[i]), res[i], 128'd0);

    for (int v = 0; v < 3; v++) run_vec(vecs[v], 0, 1'b0, 1'b0);

    // Stalled consumer, then the next block accepted straight after the handshake
    run_vec(vecs[1], 5, 1'b0, 1'b0);
    run_vec(vecs[0], 0, 1'b0, 1'b0);

    // Inputs scrambled after accept must not leak into the result
    run_vec(vecs[2], 0, 1'b1, 1'b0);

    // Stray in_valid pulses while busy or presenting a result
    run_vec(vecs[0], 2, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_out_valid", {125'd0, out_valid}, 128'd0);
      chk("idle_in_ready", {125'd0, in_ready}, {125'd0, 3'b111});
    end

    // Reset in round 5 of the 16-lane core aborts every core
    blk      = vecs[1].blk;
    key      = vecs[1].key;
    in_valid = 3'b111;
    @(negedge clk);
    in_valid = 3'b000;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", {125'd0, out_valid}, 128'd0);
    chk("abort_in_ready", {125'd0, in_ready}, {125'd0, 3'b111});
    for (int i = 0; i < 3; i++) chk($sformatf("abort_result_l%0d", LANES[i]), res[i], 128'd0);
    run_vec(vecs[0], 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
